// File: rtl/mips_pkg.sv
// Shared MIPS definitions: special instruction words, loader FSM states and
// the command codes the debug unit sends over the UART.
package mips_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [WORD_W-1:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [WORD_W-1:0] NOP_WORD  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } fsm_state_e;

   // Command bytes from the debug unit
   typedef enum logic [7:0] {
      CMD_LOAD_PROG = 8'h01,
      CMD_RUN       = 8'h02,
      CMD_STEP      = 8'h03,
      CMD_READ_REGS = 8'h04,
      CMD_READ_MEM  = 8'h05,
      CMD_READ_PC   = 8'h06,
      CMD_RESET     = 8'h07
   } dbg_cmd_e;

   function automatic logic is_halt(input logic [WORD_W-1:0] w);
      return w == HALT_WORD;
   endfunction

endpackage

// File: rtl/ensamblador_palabra.sv
// Byte-serial word assembler: shifts BYTE_W-wide bytes in MSB-first and pulses
// word_valid_o for one cycle once a full NBITS word is available on word_o.
module ensamblador_palabra #(
   parameter int unsigned NBITS  = 32,
   parameter int unsigned BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              byte_valid_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic [NBITS-1:0]  word_o,
   output logic              word_valid_o
);

   localparam int unsigned NBYTES = NBITS / BYTE_W;
   localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NBITS-1:0] shift_q, shift_d;
   logic             valid_q, valid_d;

   // Next-state: clear discards any partial word, otherwise shift and count
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      if (clr_i) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (byte_valid_i) begin
         shift_d = {shift_q[NBITS-BYTE_W-1:0], byte_i};
         if (cnt_q == CNT_W'(NBYTES - 1)) begin
            cnt_d   = '0;
            valid_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
      end
   end

   assign word_o       = shift_q;
   assign word_valid_o = valid_q;

endmodule

// File: rtl/memoria_instrucciones_cargable.sv
// Run-time loadable instruction memory for the fetch stage: byte-serial load
// of big-endian words up to HALT or a full array, then word fetch from a byte PC.
module memoria_instrucciones_cargable
   import mips_pkg::*;
#(
   parameter  int unsigned NBITS  = 32,
   parameter  int unsigned BYTE_W = 8,
   parameter  int unsigned DEPTH  = 64,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [NBITS-1:0]  i_PC,
   input  logic              i_fetch_en,
   output logic [NBITS-1:0]  o_Instruction,
   output logic              o_valid,
   output logic              o_addr_err,
   input  logic              i_load_start,
   input  logic [BYTE_W-1:0] i_load_byte,
   input  logic              i_load_valid,
   output logic              o_load_done,
   output logic [ADDR_W:0]   o_load_count,
   output logic              o_running
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   fsm_state_e         state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [NBITS-1:0]   instr_q, instr_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;
   logic               done_q, done_d;

   logic [NBITS-1:0]   mem [DEPTH];

   logic [NBITS-1:0]   asm_word;
   logic               asm_word_valid;
   logic               word_in_load_c;
   logic               finish_c;
   logic               accept_c;
   logic               we_c;
   logic [ADDR_W-1:0]  fetch_idx_c;
   logic               addr_bad_c;
   logic [NBITS-1:0]   rd_word_c;

   // A completed word is only consumed in LOAD when no restart overrides it
   assign word_in_load_c = (state_q == ST_LOAD) && asm_word_valid && !i_load_start;
   assign finish_c       = word_in_load_c &&
                           ((asm_word == NBITS'(HALT_WORD)) || (count_q == CNT_W'(DEPTH - 1)));
   assign we_c           = word_in_load_c && (count_q < CNT_W'(DEPTH));
   // Bytes arriving while the final word is committed belong to no program
   assign accept_c       = (state_q == ST_LOAD) && i_load_valid && !i_load_start && !finish_c;

   ensamblador_palabra #(
      .NBITS  (NBITS),
      .BYTE_W (BYTE_W)
   ) u_ensamblador (
      .clk          (i_clk),
      .rst_n        (i_reset),
      .clr_i        (i_load_start),
      .byte_valid_i (accept_c),
      .byte_i       (i_load_byte),
      .word_o       (asm_word),
      .word_valid_o (asm_word_valid)
   );

   assign fetch_idx_c = i_PC[ADDR_W+1:2];
   assign addr_bad_c  = (i_PC[1:0] != 2'b00) ||
                        (i_PC[NBITS-1:ADDR_W+2] != '0) ||
                        ({1'b0, fetch_idx_c} >= count_q);
   assign rd_word_c   = mem[fetch_idx_c];

   // Instruction array, no reset so it maps onto block RAM
   always_ff @(posedge i_clk) begin
      if (we_c) begin
         mem[count_q[ADDR_W-1:0]] <= asm_word;
      end
   end

   // Next-state and output-register logic
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      instr_d = instr_q;
      valid_d = 1'b0;
      err_d   = err_q;
      done_d  = 1'b0;

      if (i_load_start) begin
         state_d = ST_LOAD;
         count_d = '0;
         instr_d = NBITS'(NOP_WORD);
         err_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_LOAD: begin
               if (we_c) begin
                  count_d = count_q + CNT_W'(1);
               end
               if (finish_c) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
               end
            end
            ST_RUN: begin
               if (i_fetch_en) begin
                  valid_d = 1'b1;
                  if (addr_bad_c) begin
                     instr_d = NBITS'(NOP_WORD);
                     err_d   = 1'b1;
                  end else begin
                     instr_d = rd_word_c;
                     err_d   = 1'b0;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign o_Instruction = instr_q;
   assign o_valid       = valid_q;
   assign o_addr_err    = err_q;
   assign o_load_done   = done_q;
   assign o_load_count  = count_q;
   assign o_running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_memoria_instrucciones_cargable.sv
// Self-checking bench for the loadable instruction memory against a word-level
// model of the loaded program.
module tb_memoria_instrucciones_cargable;

   localparam int NB    = 32;
   localparam int BW    = 8;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          i_clk;
   logic          i_reset;
   logic [NB-1:0] i_PC;
   logic          i_fetch_en;
   logic [NB-1:0] o_Instruction;
   logic          o_valid;
   logic          o_addr_err;
   logic          i_load_start;
   logic [BW-1:0] i_load_byte;
   logic          i_load_valid;
   logic          o_load_done;
   logic [AW:0]   o_load_count;
   logic          o_running;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_mem [DEPTH];
   int          m_count = 0;

   memoria_instrucciones_cargable #(.NBITS(NB), .BYTE_W(BW), .DEPTH(DEPTH)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_PC          (i_PC),
      .i_fetch_en    (i_fetch_en),
      .o_Instruction (o_Instruction),
      .o_valid       (o_valid),
      .o_addr_err    (o_addr_err),
      .i_load_start  (i_load_start),
      .i_load_byte   (i_load_byte),
      .i_load_valid  (i_load_valid),
      .o_load_done   (o_load_done),
      .o_load_count  (o_load_count),
      .o_running     (o_running)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_load_byte  = b;
      i_load_valid = 1'b1;
      tick();
      i_load_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
   endtask

   task automatic load_word(input logic [31:0] w);
      send_word(w);
      if (m_count < DEPTH) begin
         m_mem[m_count] = w;
         m_count++;
      end
   endtask

   task automatic pulse_start();
      i_load_start = 1'b1;
      tick();
      i_load_start = 1'b0;
      m_count = 0;
   endtask

   task automatic do_fetch(input logic [31:0] pc);
      i_PC       = pc;
      i_fetch_en = 1'b1;
      tick();
      i_fetch_en = 1'b0;
   endtask

   // Program-level model: aligned and below the loaded word count, else NOP + error
   function automatic void exp_fetch(input logic [31:0] pc, output logic [31:0] ins,
                                     output logic err);
      if ((pc % 4) != 0 || (pc / 4) >= m_count) begin
         ins = 32'h0;
         err = 1'b1;
      end else begin
         ins = m_mem[pc / 4];
         err = 1'b0;
      end
   endfunction

   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (o_load_done === 1'b1) begin
            seen = 1;
            break;
         end
         tick();
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL %s_done: load_done never seen within 20 cycles", tag);
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b0;
      #12;
      n_cmp++;
      if ({o_Instruction, o_valid, o_addr_err, o_load_done, o_load_count, o_running} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: instr=%h valid=%b err=%b done=%b cnt=%0d run=%b, expected all 0",
                  o_Instruction, o_valid, o_addr_err, o_load_done, o_load_count, o_running);
      end
      @(negedge i_clk);
      i_reset = 1'b1;
      m_count = 0;
      tick();
      n_cmp++;
      if (o_running !== 1'b0 || o_load_count !== '0) begin
         n_bad++;
         $display("FAIL reset_idle: run=%b cnt=%0d, expected 0/0", o_running, o_load_count);
      end
   endtask

   task automatic test_basic_load();
      logic [31:0] ei; logic ee;
      pulse_start();
      load_word(32'h0022_1820);
      load_word(32'hFFFF_FFFF);
      wait_done("basic");
      n_cmp++;
      if (o_load_count !== 7'(m_count) || o_running !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_count: cnt=%0d run=%b, expected %0d/1", o_load_count, o_running, m_count);
      end
      do_fetch(32'h0);
      n_cmp++;
      if (o_Instruction !== 32'h0022_1820 || o_valid !== 1'b1 || o_addr_err !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_fetch0: instr=%h v=%b e=%b, expected 00221820/1/0",
                  o_Instruction, o_valid, o_addr_err);
      end
      n_cmp++;
      if (o_load_done !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_done_pulse: done=%b one cycle later, expected 0", o_load_done);
      end
      foreach (m_mem[i]) if (i < 0) m_mem[i] = 0;
      for (int i = 0; i < 3; i++) begin
         logic [31:0] pcs [3];
         pcs = '{32'd4, 32'd8, 32'd2};
         exp_fetch(pcs[i], ei, ee);
         do_fetch(pcs[i]);
         n_cmp++;
         if (o_Instruction !== ei || o_addr_err !== ee || o_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_pc%0d: instr=%h e=%b v=%b, expected %h/%b/1",
                     pcs[i], o_Instruction, o_addr_err, o_valid, ei, ee);
         end
      end
   endtask

   task automatic test_full_load();
      logic [31:0] w, ei; logic ee;
      pulse_start();
      for (int i = 0; i < DEPTH; i++) begin
         w = $urandom;
         if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
         load_word(w);
      end
      send_byte(8'hAB);
      n_cmp++;
      if (o_load_done !== 1'b1 || o_running !== 1'b1 || o_load_count !== 7'(DEPTH)) begin
         n_bad++;
         $display("FAIL full_done: done=%b run=%b cnt=%0d, expected 1/1/%0d",
                  o_load_done, o_running, o_load_count, DEPTH);
      end
      send_word(32'h5555_AAAA);
      n_cmp++;
      if (o_load_count !== 7'(DEPTH) || o_running !== 1'b1) begin
         n_bad++;
         $display("FAIL full_extra: cnt=%0d run=%b, expected %0d/1", o_load_count, o_running, DEPTH);
      end
      do_fetch(32'd252);
      n_cmp++;
      if (o_Instruction !== m_mem[63] || o_addr_err !== 1'b0) begin
         n_bad++;
         $display("FAIL full_pc252: instr=%h e=%b, expected %h/0", o_Instruction, o_addr_err, m_mem[63]);
      end
      for (int i = 0; i < 16; i++) begin
         logic [31:0] pc;
         pc = 32'($urandom_range(0, 63)) * 4;
         if (i == 15) pc = 32'd256;
         exp_fetch(pc, ei, ee);
         do_fetch(pc);
         n_cmp++;
         if (o_Instruction !== ei || o_addr_err !== ee) begin
            n_bad++;
            $display("FAIL full_fetch pc=%0d: instr=%h e=%b, expected %h/%b", pc, o_Instruction,
                     o_addr_err, ei, ee);
         end
      end
   endtask

   task automatic test_restart_partial();
      pulse_start();
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
      pulse_start();
      load_word(32'h2001_000A);
      load_word(32'hFFFF_FFFF);
      wait_done("restart");
      n_cmp++;
      if (o_load_count !== 7'd2) begin
         n_bad++;
         $display("FAIL restart_count: cnt=%0d, expected 2", o_load_count);
      end
      do_fetch(32'h0);
      n_cmp++;
      if (o_Instruction !== 32'h2001_000A || o_addr_err !== 1'b0) begin
         n_bad++;
         $display("FAIL restart_mem0: instr=%h e=%b, expected 2001000a/0", o_Instruction, o_addr_err);
      end
   endtask

   task automatic test_reset_midload();
      pulse_start();
      load_word(32'h0123_4567);
      send_byte(8'h11); send_byte(8'h22);
      i_reset = 1'b0;
      #2;
      n_cmp++;
      if ({o_Instruction, o_valid, o_addr_err, o_load_done, o_load_count, o_running} !== '0) begin
         n_bad++;
         $display("FAIL midreset_outputs: instr=%h v=%b e=%b d=%b cnt=%0d run=%b, expected all 0",
                  o_Instruction, o_valid, o_addr_err, o_load_done, o_load_count, o_running);
      end
      @(negedge i_clk);
      i_reset = 1'b1;
      m_count = 0;
      i_PC = 32'h0;
      i_fetch_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (o_valid !== 1'b0 || o_running !== 1'b0 || o_Instruction !== 32'h0) begin
            n_bad++;
            $display("FAIL midreset_idle_fetch: v=%b run=%b instr=%h, expected 0/0/0",
                     o_valid, o_running, o_Instruction);
         end
      end
      i_fetch_en = 1'b0;
      pulse_start();
      load_word(32'h8C01_0004);
      load_word(32'hFFFF_FFFF);
      wait_done("reload");
      do_fetch(32'h0);
      n_cmp++;
      if (o_Instruction !== 32'h8C01_0004) begin
         n_bad++;
         $display("FAIL reload_mem0: instr=%h, expected 8c010004", o_Instruction);
      end
   endtask

   task automatic test_hold_and_start_in_run();
      do_fetch(32'd4);
      for (int i = 0; i < 3; i++) begin
         i_PC = 32'h0;
         tick();
         n_cmp++;
         if (o_Instruction !== 32'hFFFF_FFFF || o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_%0d: instr=%h v=%b, expected ffffffff/0", i, o_Instruction, o_valid);
         end
      end
      i_fetch_en = 1'b1;
      pulse_start();
      i_fetch_en = 1'b0;
      n_cmp++;
      if (o_running !== 1'b0 || o_Instruction !== 32'h0 || o_valid !== 1'b0 ||
          o_addr_err !== 1'b0 || o_load_count !== '0) begin
         n_bad++;
         $display("FAIL start_in_run: run=%b instr=%h v=%b e=%b cnt=%0d, expected 0/0/0/0/0",
                  o_running, o_Instruction, o_valid, o_addr_err, o_load_count);
      end
   endtask

   task automatic test_random_program();
      logic [31:0] w, pc, ei, ee_ins; logic ee, en;
      int n;
      // Byte presented together with start must be dropped
      i_load_start = 1'b1; i_load_valid = 1'b1; i_load_byte = 8'($urandom);
      tick();
      i_load_start = 1'b0; i_load_valid = 1'b0;
      m_count = 0;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         if (w == 32'hFFFF_FFFF) w = 32'h0;
         load_word(w);
      end
      load_word(32'hFFFF_FFFF);
      wait_done("rand");
      n_cmp++;
      if (o_load_count !== 7'(m_count)) begin
         n_bad++;
         $display("FAIL rand_count: cnt=%0d, expected %0d", o_load_count, m_count);
      end
      ei = o_Instruction; ee = o_addr_err;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0, 1:    pc = 32'($urandom_range(0, m_count - 1)) * 4;
            2:       pc = 32'($urandom_range(0, m_count - 1)) * 4 + 32'($urandom_range(1, 3));
            default: pc = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0100;
         endcase
         en = ($urandom_range(0, 3) != 0);
         i_PC = pc; i_fetch_en = en;
         tick();
         i_fetch_en = 1'b0;
         if (en) exp_fetch(pc, ei, ee);
         ee_ins = ei;
         n_cmp++;
         if (o_Instruction !== ee_ins || o_addr_err !== ee || o_valid !== en) begin
            n_bad++;
            $display("FAIL rand_fetch pc=%h en=%b: instr=%h e=%b v=%b, expected %h/%b/%b",
                     pc, en, o_Instruction, o_addr_err, o_valid, ee_ins, ee, en);
         end
      end
   endtask

   initial begin
      i_reset = 1'b0; i_PC = '0; i_fetch_en = 1'b0;
      i_load_start = 1'b0; i_load_byte = '0; i_load_valid = 1'b0;
      test_reset();
      test_basic_load();
      test_full_load();
      test_restart_partial();
      test_reset_midload();
      test_hold_and_start_in_run();
      test_random_program();
      test_random_program();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
